// File: rtl/guess_round_controller.sv
// guess_round_controller
//
// Sequencing controller for the number-guessing game. It runs three levels
// (1, 2 and 3 digits) of three rounds each. For every round it presents
// Max_digit/round to an external target lookup. Each accepted 3-digit BCD
// guess is compared against the target the lookup returns. The block reports
// high/low/correct hints, counts attempts and flags the final win or loss.
//
// Ports
//   Clk                     rising-edge clock
//   Reset                   asynchronous, active-high; forces IDLE, outputs 0
//   start                   one-cycle pulse; new game from IDLE/WIN/LOSE
//   guess_valid             one-cycle pulse; guess offered, taken in WAIT
//   guess_digit_3..1        guess digits, hundreds to ones
//   target_digit_3..1       combinational return of the target lookup
//   Max_digit               current level (1..3), 0 in IDLE
//   round                   current round (1..3), 0 in IDLE
//   guess_ready             high exactly while in WAIT
//   hint_high/low/correct   one-hot or zero; high means guess > target
//   tries                   guesses accepted in the current round
//   score                   rounds cleared in this game (0..9)
//   win, lose               game result flags
module guess_round_controller #(
  parameter int MAX_TRIES = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       start,
  input  logic       guess_valid,
  input  logic [3:0] guess_digit_3,
  input  logic [3:0] guess_digit_2,
  input  logic [3:0] guess_digit_1,
  input  logic [3:0] target_digit_3,
  input  logic [3:0] target_digit_2,
  input  logic [3:0] target_digit_1,
  output logic [1:0] Max_digit,
  output logic [1:0] round,
  output logic       guess_ready,
  output logic       hint_high,
  output logic       hint_low,
  output logic       hint_correct,
  output logic [3:0] tries,
  output logic [3:0] score,
  output logic       win,
  output logic       lose
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CHECK,
    ST_ADVANCE,
    ST_WIN,
    ST_LOSE
  } state_t;

  localparam logic [3:0] TRIES_LIMIT = 4'(MAX_TRIES);

  // Digits above the current level are forced to zero so that stray upper
  // digits on the keypad never affect a 1- or 2-digit round.
  function automatic logic [11:0] mask_guess(input logic [1:0] level,
                                             input logic [3:0] d3,
                                             input logic [3:0] d2,
                                             input logic [3:0] d1);
    logic [11:0] word;
    case (level)
      2'd1:    word = {4'd0, 4'd0, d1};
      2'd2:    word = {4'd0, d2, d1};
      default: word = {d3, d2, d1};
    endcase
    return word;
  endfunction

  state_t      state, state_nxt;
  logic [1:0]  max_digit_nxt;
  logic [1:0]  round_nxt;
  logic        guess_ready_nxt;
  logic        hint_high_nxt;
  logic        hint_low_nxt;
  logic        hint_correct_nxt;
  logic [3:0]  tries_nxt;
  logic [3:0]  score_nxt;
  logic        win_nxt;
  logic        lose_nxt;

  logic        capture;
  logic [11:0] guess_p1;
  logic [11:0] target_word;

  assign capture     = (state == ST_WAIT) && guess_valid;
  assign target_word = {target_digit_3, target_digit_2, target_digit_1};

  // Capture stage: masked guess held for the CHECK cycle.
  always_ff @(posedge Clk) begin
    if (capture) begin
      guess_p1 <= mask_guess(Max_digit, guess_digit_3, guess_digit_2, guess_digit_1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= ST_IDLE;
      Max_digit    <= 2'd0;
      round        <= 2'd0;
      guess_ready  <= 1'b0;
      hint_high    <= 1'b0;
      hint_low     <= 1'b0;
      hint_correct <= 1'b0;
      tries        <= 4'd0;
      score        <= 4'd0;
      win          <= 1'b0;
      lose         <= 1'b0;
    end else begin
      state        <= state_nxt;
      Max_digit    <= max_digit_nxt;
      round        <= round_nxt;
      guess_ready  <= guess_ready_nxt;
      hint_high    <= hint_high_nxt;
      hint_low     <= hint_low_nxt;
      hint_correct <= hint_correct_nxt;
      tries        <= tries_nxt;
      score        <= score_nxt;
      win          <= win_nxt;
      lose         <= lose_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    max_digit_nxt    = Max_digit;
    round_nxt        = round;
    hint_high_nxt    = hint_high;
    hint_low_nxt     = hint_low;
    hint_correct_nxt = hint_correct;
    tries_nxt        = tries;
    score_nxt        = score;
    win_nxt          = win;
    lose_nxt         = lose;

    case (state)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        // A simultaneous guess_valid is simply not looked at here.
        if (start) begin
          state_nxt        = ST_WAIT;
          max_digit_nxt    = 2'd1;
          round_nxt        = 2'd1;
          tries_nxt        = 4'd0;
          score_nxt        = 4'd0;
          hint_high_nxt    = 1'b0;
          hint_low_nxt     = 1'b0;
          hint_correct_nxt = 1'b0;
          win_nxt          = 1'b0;
          lose_nxt         = 1'b0;
        end
      end

      ST_WAIT: begin
        if (guess_valid) begin
          state_nxt        = ST_CHECK;
          tries_nxt        = tries + 4'd1;
          hint_high_nxt    = 1'b0;
          hint_low_nxt     = 1'b0;
          hint_correct_nxt = 1'b0;
        end
      end

      ST_CHECK: begin
        // Plain unsigned compare of the packed digits; non-BCD nibbles
        // order numerically like any other value.
        if (guess_p1 == target_word) begin
          hint_correct_nxt = 1'b1;
          score_nxt        = score + 4'd1;
          state_nxt        = ST_ADVANCE;
        end else begin
          hint_high_nxt = (guess_p1 > target_word);
          hint_low_nxt  = (guess_p1 < target_word);
          if (tries == TRIES_LIMIT) begin
            state_nxt = ST_LOSE;
            lose_nxt  = 1'b1;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
      end

      ST_ADVANCE: begin
        tries_nxt = 4'd0;
        if (round < 2'd3) begin
          round_nxt = round + 2'd1;
          state_nxt = ST_WAIT;
        end else if (Max_digit < 2'd3) begin
          max_digit_nxt = Max_digit + 2'd1;
          round_nxt     = 2'd1;
          state_nxt     = ST_WAIT;
        end else begin
          state_nxt = ST_WIN;
          win_nxt   = 1'b1;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Registered copy of "next state is WAIT" keeps guess_ready glitch-free
    // and aligned with the state register.
    guess_ready_nxt = (state_nxt == ST_WAIT);
  end

endmodule

// File: tb/tb_guess_round_controller.sv
// Directed, table-driven bench for guess_round_controller with a behavioural
// target lookup (level/round -> fixed 3-digit target).
module tb_guess_round_controller;

  logic       Clk;
  logic       Reset;
  logic       start;
  logic       guess_valid;
  logic [3:0] guess_digit_3, guess_digit_2, guess_digit_1;
  logic [3:0] target_digit_3, target_digit_2, target_digit_1;
  logic [1:0] Max_digit;
  logic [1:0] round;
  logic       guess_ready;
  logic       hint_high, hint_low, hint_correct;
  logic [3:0] tries;
  logic [3:0] score;
  logic       win, lose;

  int n_checks = 0;
  int n_fail   = 0;

  guess_round_controller #(.MAX_TRIES(8)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .start         (start),
    .guess_valid   (guess_valid),
    .guess_digit_3 (guess_digit_3),
    .guess_digit_2 (guess_digit_2),
    .guess_digit_1 (guess_digit_1),
    .target_digit_3(target_digit_3),
    .target_digit_2(target_digit_2),
    .target_digit_1(target_digit_1),
    .Max_digit     (Max_digit),
    .round         (round),
    .guess_ready   (guess_ready),
    .hint_high     (hint_high),
    .hint_low      (hint_low),
    .hint_correct  (hint_correct),
    .tries         (tries),
    .score         (score),
    .win           (win),
    .lose          (lose)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Target lookup: level 1 -> 2, 8, 3; level 2 -> 57, 96, 21; level 3 -> 123, 000, 999.
  always_comb begin
    {target_digit_3, target_digit_2, target_digit_1} = 12'h000;
    case ({Max_digit, round})
      4'b01_01: {target_digit_3, target_digit_2, target_digit_1} = 12'h002;
      4'b01_10: {target_digit_3, target_digit_2, target_digit_1} = 12'h008;
      4'b01_11: {target_digit_3, target_digit_2, target_digit_1} = 12'h003;
      4'b10_01: {target_digit_3, target_digit_2, target_digit_1} = 12'h057;
      4'b10_10: {target_digit_3, target_digit_2, target_digit_1} = 12'h096;
      4'b10_11: {target_digit_3, target_digit_2, target_digit_1} = 12'h021;
      4'b11_01: {target_digit_3, target_digit_2, target_digit_1} = 12'h123;
      4'b11_10: {target_digit_3, target_digit_2, target_digit_1} = 12'h000;
      4'b11_11: {target_digit_3, target_digit_2, target_digit_1} = 12'h999;
      default:  {target_digit_3, target_digit_2, target_digit_1} = 12'h000;
    endcase
  end

  typedef struct {
    logic       st;      // pulse start before this guess
    logic [3:0] d3, d2, d1;
    logic [2:0] hint;    // {high, low, correct} after CHECK
    logic [3:0] tries;   // settled values (after ADVANCE if correct)
    logic [3:0] score;
    logic [1:0] maxd;
    logic [1:0] rnd;
    logic       rdy;
    logic       win;
    logic       lose;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic st, input logic [3:0] d3, input logic [3:0] d2,
                              input logic [3:0] d1, input logic [2:0] hint,
                              input logic [3:0] t, input logic [3:0] s,
                              input logic [1:0] m, input logic [1:0] r,
                              input logic rdy, input logic w, input logic l);
    vec_t v;
    v.st = st; v.d3 = d3; v.d2 = d2; v.d1 = d1; v.hint = hint;
    v.tries = t; v.score = s; v.maxd = m; v.rnd = r;
    v.rdy = rdy; v.win = w; v.lose = l;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_maxd"},  32'(Max_digit), 32'd0);
    check({tag, "_round"}, 32'(round), 32'd0);
    check({tag, "_ready"}, 32'(guess_ready), 32'd0);
    check({tag, "_hints"}, 32'({hint_high, hint_low, hint_correct}), 32'd0);
    check({tag, "_tries"}, 32'(tries), 32'd0);
    check({tag, "_score"}, 32'(score), 32'd0);
    check({tag, "_winlose"}, 32'({win, lose}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    start = 1'b0;
    guess_valid = 1'b0;
    {guess_digit_3, guess_digit_2, guess_digit_1} = 12'h000;

    // Reset state, then release and confirm the block waits in IDLE.
    #2;
    check_all_zero("reset");
    tick();
    tick();
    Reset = 1'b0;
    tick();
    tick();
    check_all_zero("idle");

    // Game 1: hints and non-BCD digit in round 1, then the full nine-round win.
    vq.push_back(mk(1, 0, 0, 5,   3'b100, 1, 0, 1, 1, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 1,   3'b010, 2, 0, 1, 1, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 10,  3'b100, 3, 0, 1, 1, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 2,   3'b001, 0, 1, 1, 2, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 8,   3'b001, 0, 2, 1, 3, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 3,   3'b001, 0, 3, 2, 1, 1, 0, 0));
    vq.push_back(mk(0, 0, 5, 7,   3'b001, 0, 4, 2, 2, 1, 0, 0));
    vq.push_back(mk(0, 0, 9, 6,   3'b001, 0, 5, 2, 3, 1, 0, 0));
    vq.push_back(mk(0, 0, 2, 1,   3'b001, 0, 6, 3, 1, 1, 0, 0));
    vq.push_back(mk(0, 1, 2, 3,   3'b001, 0, 7, 3, 2, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0,   3'b001, 0, 8, 3, 3, 1, 0, 0));
    vq.push_back(mk(0, 9, 9, 9,   3'b001, 0, 9, 3, 3, 0, 1, 0));
    // Game 2: restart from WIN, masked guess 7,7,2 at level 1, then loss at level 2.
    vq.push_back(mk(1, 7, 7, 2,   3'b001, 0, 1, 1, 2, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 8,   3'b001, 0, 2, 1, 3, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 3,   3'b001, 0, 3, 2, 1, 1, 0, 0));
    for (int k = 1; k <= 7; k++) begin
      vq.push_back(mk(0, 0, 5, 8, 3'b100, 4'(k), 3, 2, 1, 1, 0, 0));
    end
    vq.push_back(mk(0, 0, 5, 8,   3'b100, 8, 3, 2, 1, 0, 0, 1));

    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].st) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        check($sformatf("v%0d_start_ready", i), 32'(guess_ready), 32'd1);
        check($sformatf("v%0d_start_winlose", i), 32'({win, lose}), 32'd0);
      end
      {guess_digit_3, guess_digit_2, guess_digit_1} = {vq[i].d3, vq[i].d2, vq[i].d1};
      guess_valid = 1'b1;
      tick();
      guess_valid = 1'b0;
      tick();
      check($sformatf("v%0d_hint", i), 32'({hint_high, hint_low, hint_correct}), 32'(vq[i].hint));
      if (vq[i].hint[0]) tick();
      check($sformatf("v%0d_tries", i), 32'(tries), 32'(vq[i].tries));
      check($sformatf("v%0d_score", i), 32'(score), 32'(vq[i].score));
      check($sformatf("v%0d_maxd", i), 32'(Max_digit), 32'(vq[i].maxd));
      check($sformatf("v%0d_round", i), 32'(round), 32'(vq[i].rnd));
      check($sformatf("v%0d_ready", i), 32'(guess_ready), 32'(vq[i].rdy));
      check($sformatf("v%0d_win", i), 32'(win), 32'(vq[i].win));
      check($sformatf("v%0d_lose", i), 32'(lose), 32'(vq[i].lose));
    end

    // LOSE: guess_valid is ignored.
    {guess_digit_3, guess_digit_2, guess_digit_1} = 12'h057;
    guess_valid = 1'b1;
    tick();
    guess_valid = 1'b0;
    tick();
    check("lose_ignore_tries", 32'(tries), 32'd8);
    check("lose_ignore_lose", 32'(lose), 32'd1);
    check("lose_ignore_hint", 32'({hint_high, hint_low, hint_correct}), 32'b100);

    // LOSE: start and guess_valid together -> new game, guess dropped.
    {guess_digit_3, guess_digit_2, guess_digit_1} = 12'h002;
    start = 1'b1;
    guess_valid = 1'b1;
    tick();
    start = 1'b0;
    guess_valid = 1'b0;
    check("both_ready", 32'(guess_ready), 32'd1);
    check("both_tries", 32'(tries), 32'd0);
    check("both_lose", 32'(lose), 32'd0);
    check("both_level", 32'({Max_digit, round}), 32'b01_01);
    check("both_hints", 32'({hint_high, hint_low, hint_correct}), 32'd0);
    tick();
    check("both_no_check", 32'(tries), 32'd0);

    // Clear round 1, then start in WAIT must be ignored.
    guess_valid = 1'b1;
    tick();
    guess_valid = 1'b0;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("wait_start_level", 32'({Max_digit, round}), 32'b01_10);
    check("wait_start_score", 32'(score), 32'd1);
    check("wait_start_ready", 32'(guess_ready), 32'd1);

    // guess_valid held through CHECK: only the first edge counts.
    {guess_digit_3, guess_digit_2, guess_digit_1} = 12'h009;
    guess_valid = 1'b1;
    tick();
    tick();
    guess_valid = 1'b0;
    check("chk_valid_tries", 32'(tries), 32'd1);
    check("chk_valid_hint", 32'({hint_high, hint_low, hint_correct}), 32'b100);
    tick();
    check("chk_valid_tries2", 32'(tries), 32'd1);

    // guess_valid held through CHECK and ADVANCE with a correct guess.
    {guess_digit_3, guess_digit_2, guess_digit_1} = 12'h008;
    guess_valid = 1'b1;
    tick();
    tick();
    tick();
    guess_valid = 1'b0;
    check("adv_valid_round", 32'(round), 32'd3);
    check("adv_valid_tries", 32'(tries), 32'd0);
    check("adv_valid_score", 32'(score), 32'd2);
    check("adv_valid_ready", 32'(guess_ready), 32'd1);
    tick();
    check("adv_valid_tries2", 32'(tries), 32'd0);

    // Asynchronous reset mid-CHECK.
    {guess_digit_3, guess_digit_2, guess_digit_1} = 12'h001;
    guess_valid = 1'b1;
    tick();
    guess_valid = 1'b0;
    check("pre_reset_tries", 32'(tries), 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    check_all_zero("async");
    #1;
    Reset = 1'b0;
    tick();
    check_all_zero("post_reset");
    guess_valid = 1'b1;
    tick();
    guess_valid = 1'b0;
    tick();
    check_all_zero("idle_ignore");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
